audio_stream_bridge: RTL
========================

# audio_stream_bridge

Parametrised, elastic successor to the single-register codec transfer path: moves CH-channel sample frames from the audio codec input FIFO to the codec output FIFO through a DEPTH-frame buffer with independent, correctly pulsed read and write handshakes. A click-free ramped mute (replacing the hard switch mute) is applied on the output side. It sits between the codec interface and the effect chain input/output taps in `top`.

## Interface

Parameters:
- DATA_W, 32, bits per channel sample (signed, two's complement)
- CH, 2, channels per frame (channel 0 in bits [DATA_W-1:0], i.e. L)
- DEPTH, 4, frame buffer depth; power of two, at least 2
- GAIN_W, 6, ramp resolution; a full ramp is 2^GAIN_W output frames

Ports:
- CLOCK_50, in, 1, sole clock, rising edge
- resetn, in, 1, asynchronous active-low reset
- audio_in_available, in, 1, codec has a frame on audio_in
- audio_in, in, CH*DATA_W, codec input frame
- read_audio_in, out, 1, one-cycle pop strobe to codec input
- audio_out_allowed, in, 1, codec output FIFO has space
- audio_out, out, CH*DATA_W, frame to codec output
- write_audio_out, out, 1, one-cycle push strobe to codec output
- mute_req, in, 1, level: 1 = ramp to silence, 0 = ramp to unity
- mute_done, out, 1, high while fully muted
- fill, out, $clog2(DEPTH)+1, frames currently buffered

## Operation

- Read side: on an edge where audio_in_available=1, fill<DEPTH and read_audio_in=0, the block stores audio_in at the write pointer and drives read_audio_in=1 for the next cycle only. Back-to-back read strobes never occur.
- Write side: on an edge where audio_out_allowed=1, fill>0 and write_audio_out=0, the block pops the head frame, registers the gained frame into audio_out and drives write_audio_out=1 for the next cycle only. audio_out holds its value between writes.
- Simultaneous push and pop on one edge: fill is unchanged. Pointers wrap modulo DEPTH.
- Full: the read strobe is withheld and the codec is backpressured; no frame is lost or overwritten. Empty: the write strobe is withheld and audio_out is not updated.
- Gain g ranges from 0 to 2^GAIN_W. Each channel out = (sample * g) >>> GAIN_W.
  - The product is DATA_W+GAIN_W+1 signed bits, uses an arithmetic shift, and is truncated to DATA_W.
  - g=2^GAIN_W is bit-exact pass-through. g=0 gives 0.
- Mute FSM states: UNITY (g=max), DOWN, MUTED (g=0), UP.
  - UNITY goes to DOWN on mute_req=1. MUTED goes to UP on mute_req=0.
  - DOWN decrements g by 1 per popped frame and enters MUTED at g=0.
  - UP increments g by 1 per popped frame and enters UNITY at g=max.
  - A mute_req change mid-ramp switches directly DOWN to UP (or UP to DOWN) from the current g, with no jump.
  - g changes only on pop edges. The popped frame uses the pre-step g.
- mute_done=1 only in MUTED.

## Timing

- Reset values: read_audio_in=0, write_audio_out=0, audio_out=0, fill=0, mute_done=0, pointers=0, FSM=UNITY, g=2^GAIN_W.
- Reset asserted mid-operation discards all buffered frames and aborts any ramp. Strobes drop in the same instant, asynchronously.
- Latency: a frame accepted at edge t can be popped at edge t+1 at the earliest, so write_audio_out is high in cycle t+2.
- fill is registered and reflects both edge updates in the following cycle.
- Maximum throughput is one frame per 2 cycles per side.

## Configuration

- AUDIO_BRIDGE_STATS_EN defined adds two outputs:
  - overrun_cnt, 16 bits: increments on each edge with audio_in_available=1 while fill=DEPTH.
  - underrun_cnt, 16 bits: increments on each edge with audio_out_allowed=1 while fill=0.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters are absent. All other behaviour is identical.

## Test plan

- Reset then a single frame L=32'h0000_1234, R=32'hFFFF_0000 with allowed=1 -> one read pulse, then audio_out equals the input exactly with write pulse at cycle t+2, fill returns to 0.
- allowed=0, available=1 held -> exactly DEPTH=4 read pulses, never consecutive; fill=4 and read_audio_in stays 0 thereafter.
- Release allowed=1 with available held -> strobes on both sides alternate, fill stays stable, and frames leave in FIFO order (tagged counting pattern).
- mute_req=1 with GAIN_W=6 and sample 32'h0100_0000 -> 64 outputs stepping down by 32'h0004_0000 each, then 0 and mute_done=1. mute_req=0 at g=20 mid-ramp -> next gains are 20, then 21 and upward.
- Negative sample 32'h8000_0000 at g=1 -> output 32'hFE00_0000, confirming arithmetic shift.
- With AUDIO_BRIDGE_STATS_EN: 10 edges with available=1 while full -> overrun_cnt=10. Assert resetn=0 mid-transfer -> all outputs return to their reset values immediately.

Source files
------------

// File: rtl/audio_stream_bridge.sv
// Elastic CH-channel frame FIFO from codec input to codec output, with a
// click-free ramped mute on the output side. AUDIO_BRIDGE_STATS_EN adds over/underrun counters.

module audio_gain_lane #(
  parameter int DATA_W = 32,
  parameter int GAIN_W = 6
) (
  input  logic [DATA_W-1:0] sample,
  input  logic [GAIN_W:0]   gain,
  output logic [DATA_W-1:0] scaled
);
  localparam int PW = DATA_W + GAIN_W + 1;

  logic signed [PW-1:0] sx, gx, prod;
  logic                 unused_prod;

  assign sx = {{(GAIN_W+1){sample[DATA_W-1]}}, sample};
  assign gx = {{DATA_W{1'b0}}, gain};
  assign prod = sx * gx;
  // Arithmetic shift right by GAIN_W, then truncate to DATA_W.
  assign scaled = prod[GAIN_W +: DATA_W];
  assign unused_prod = ^{prod[PW-1], prod[GAIN_W-1:0]};
endmodule

module audio_stream_bridge #(
  parameter int DATA_W = 32,
  parameter int CH     = 2,
  parameter int DEPTH  = 4,
  parameter int GAIN_W = 6
) (
  input  logic                   CLOCK_50,
  input  logic                   resetn,
  input  logic                   audio_in_available,
  input  logic [CH*DATA_W-1:0]   audio_in,
  output logic                   read_audio_in,
  input  logic                   audio_out_allowed,
  output logic [CH*DATA_W-1:0]   audio_out,
  output logic                   write_audio_out,
  input  logic                   mute_req,
  output logic                   mute_done,
  output logic [$clog2(DEPTH):0] fill
`ifdef AUDIO_BRIDGE_STATS_EN
  ,
  output logic [15:0]            overrun_cnt,
  output logic [15:0]            underrun_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam logic [FW-1:0]     FULL  = FW'(DEPTH);
  localparam logic [GAIN_W:0]   G_MAX = {1'b1, {GAIN_W{1'b0}}};

  typedef logic [CH-1:0][DATA_W-1:0] frame_t;
  typedef enum logic [1:0] {UNITY, DOWN, MUTED, UP} mute_st_t;

  frame_t          mem [DEPTH];
  frame_t          head, gained;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            push, pop;
  logic [GAIN_W:0] g, g_nxt;
  mute_st_t        st, st_nxt;

  // The strobe terms keep each side to one transfer per two cycles.
  assign push = audio_in_available && (fill < FULL) && !read_audio_in;
  assign pop  = audio_out_allowed && (fill != '0) && !write_audio_out;
  assign head = mem[rd_ptr];
  assign mute_done = (st == MUTED);

  for (genvar c = 0; c < CH; c++) begin : g_lane
    audio_gain_lane #(.DATA_W(DATA_W), .GAIN_W(GAIN_W)) u_lane (
      .sample (head[c]),
      .gain   (g),
      .scaled (gained[c])
    );
  end

  always_comb begin
    st_nxt = st;
    g_nxt  = g;
    case (st)
      UNITY:   if (mute_req)  st_nxt = DOWN;
      MUTED:   if (!mute_req) st_nxt = UP;
      DOWN:    if (!mute_req) st_nxt = UP;
      UP:      if (mute_req)  st_nxt = DOWN;
      default: st_nxt = UNITY;
    endcase
    // Step in the direction just chosen; the popped frame still sees the old g.
    if (pop) begin
      if (st_nxt == DOWN && g != '0)         g_nxt = g - (GAIN_W+1)'(1);
      else if (st_nxt == UP && g != G_MAX)   g_nxt = g + (GAIN_W+1)'(1);
    end
    if (st_nxt == DOWN && g_nxt == '0)    st_nxt = MUTED;
    if (st_nxt == UP   && g_nxt == G_MAX) st_nxt = UNITY;
  end

  always_ff @(posedge CLOCK_50) begin
    if (push) mem[wr_ptr] <= audio_in;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      read_audio_in   <= 1'b0;
      write_audio_out <= 1'b0;
      audio_out       <= '0;
      fill            <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      g               <= G_MAX;
      st              <= UNITY;
    end else begin
      read_audio_in   <= push;
      write_audio_out <= pop;
      st              <= st_nxt;
      g               <= g_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + AW'(1);
        audio_out <= gained;
      end
      case ({push, pop})
        2'b10:   fill <= fill + FW'(1);
        2'b01:   fill <= fill - FW'(1);
        default: fill <= fill;
      endcase
    end
  end

`ifdef AUDIO_BRIDGE_STATS_EN
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      overrun_cnt  <= '0;
      underrun_cnt <= '0;
    end else begin
      if (audio_in_available && fill == FULL && overrun_cnt != 16'hFFFF)
        overrun_cnt <= overrun_cnt + 16'd1;
      if (audio_out_allowed && fill == '0 && underrun_cnt != 16'hFFFF)
        underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif
endmodule
